// File: rtl/mult_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_ctrl_pkg
// Shared definitions for the two-requester multiplier arbiter.
//   state_t    : FSM state encoding (IDLE / ISSUE / WAIT / RESPOND)
//   REQ0/REQ1  : requester identifiers used for grant and winner tracking
// ---------------------------------------------------------------------------
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    RESPOND = 2'b11
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage : mult_ctrl_pkg

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-input round-robin picker. The grant history
// (last_grant) is owned by the parent.
// Ports:
//   req0, req1   in  request levels
//   last_grant   in  id granted on the previous arbitration
//   grant_valid  out at least one request present
//   grant_id     out id of the winner (meaningful only with grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import mult_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = REQ0;
    if (req0 && req1) begin
      // Tie: whoever was not served last time goes next.
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = REQ1;
    end
  end

endmodule : rr_arbiter2

// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
// Shares one start/done sequential multiplier between two requesters.
// Round-robin arbitration, operand capture, single start pulse, watchdog
// on the done wait, and a one-cycle ack with product or timeout flag.
// Parameters:
//   WIDTH    operand width (product is 2*WIDTH)
//   TIMEOUT  max WAIT cycles before abort (>= 2)
// Ports:
//   clk, reset             clock / asynchronous active-high reset
//   req0/1, a0/b0, a1/b1   requester levels and operands
//   ack0/1, res0/1, err0/1 completion pulse, held product, held timeout flag
//   mult_start, mult_a/b   start pulse and latched operands to the datapath
//   mult_done, mult_result datapath done level and product
//   busy                   high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mult_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] res0,
  output logic [2*WIDTH-1:0] res1,
  output logic               err0,
  output logic               err1,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_last_grant;
  logic               r_winner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mult_a;
  logic [WIDTH-1:0]   r_mult_b;
  logic [2*WIDTH-1:0] r_res0;
  logic [2*WIDTH-1:0] r_res1;
  logic               r_err0;
  logic               r_err1;

  logic               w_grant_valid;
  logic               w_grant_id;
  logic               w_done_ok;
  logic               w_timeout;

  rr_arbiter2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // A counter of zero marks the first WAIT cycle, where a done level left
  // over from the previous operation may still be visible, so it is ignored.
  assign w_done_ok = (r_state == WAIT) && (r_cnt != '0) && mult_done;
  assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_done_ok || w_timeout) w_state_next = RESPOND;
      RESPOND: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register (no input-to-output paths)
  always_comb begin
    mult_start = (r_state == ISSUE);
    busy       = (r_state != IDLE);
    ack0       = (r_state == RESPOND) && (r_winner == REQ0);
    ack1       = (r_state == RESPOND) && (r_winner == REQ1);
  end

  // Datapath registers: grant history, operands, wait counter, results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= REQ1;
      r_winner     <= REQ0;
      r_cnt        <= '0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_res0       <= '0;
      r_res1       <= '0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant_id;
            r_winner     <= w_grant_id;
            r_mult_a     <= (w_grant_id == REQ1) ? a1 : a0;
            r_mult_b     <= (w_grant_id == REQ1) ? b1 : b0;
          end
        end
        ISSUE: begin
          r_cnt <= '0;
        end
        WAIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // Done takes priority when it coincides with the timeout.
          if (w_done_ok) begin
            if (r_winner == REQ1) begin
              r_res1 <= mult_result;
              r_err1 <= 1'b0;
            end else begin
              r_res0 <= mult_result;
              r_err0 <= 1'b0;
            end
          end else if (w_timeout) begin
            if (r_winner == REQ1) begin
              r_res1 <= '0;
              r_err1 <= 1'b1;
            end else begin
              r_res0 <= '0;
              r_err0 <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_a = r_mult_a;
  assign mult_b = r_mult_b;
  assign res0   = r_res0;
  assign res1   = r_res1;
  assign err0   = r_err0;
  assign err1   = r_err1;

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter
// Scoreboard bench: each scenario pushes expected (id, product, err,
// start-to-ack latency) entries and pops them as acks appear.
// ---------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [15:0] res0, res1;
  logic        err0, err1;
  logic        mult_start;
  logic [7:0]  mult_a, mult_b;
  logic        mult_done;
  logic [15:0] mult_result;
  logic        busy;

  int   tests_run;
  int   tests_failed;
  exp_t sb_q[$];

  int   cyc;
  int   last_start_cyc;
  int   start_cnt;
  int   ack0_cnt;
  int   ack1_cnt;

  // Datapath model: 0 = done 5 cycles after start edge, 1 = never done,
  // 2 = done held high permanently.
  int          dp_mode;
  int          dp_cnt;
  logic        dp_done;
  logic [15:0] dp_res;

  mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .a0          (a0),
    .b0          (b0),
    .a1          (a1),
    .b1          (b1),
    .ack0        (ack0),
    .ack1        (ack1),
    .res0        (res0),
    .res1        (res1),
    .err0        (err0),
    .err1        (err1),
    .mult_start  (mult_start),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_done   (mult_done),
    .mult_result (mult_result),
    .busy        (busy)
  );

  assign mult_done   = dp_done;
  assign mult_result = dp_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dp_mode == 2) begin
      dp_done <= 1'b1;
      dp_res  <= 16'(mult_a) * 16'(mult_b);
      dp_cnt  <= 0;
    end else if (dp_mode == 1) begin
      dp_done <= 1'b0;
      dp_cnt  <= 0;
    end else if (mult_start) begin
      dp_cnt  <= 1;
      dp_done <= 1'b0;
      dp_res  <= 16'(mult_a) * 16'(mult_b);
    end else if (dp_cnt == 5) begin
      dp_done <= 1'b1;
      dp_cnt  <= 0;
    end else if (dp_cnt != 0) begin
      dp_cnt <= dp_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mult_start === 1'b1) begin
      last_start_cyc <= cyc;
      start_cnt      <= start_cnt + 1;
    end
    if (ack0 === 1'b1) ack0_cnt <= ack0_cnt + 1;
    if (ack1 === 1'b1) ack1_cnt <= ack1_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Bounded wait for any ack; reports latency from the last start pulse.
  task automatic await_ack(input int budget, output bit got, output logic id, output int lat);
    got = 1'b0;
    id  = 1'b0;
    lat = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        got = 1'b1;
        id  = ack1;
        lat = cyc - last_start_cyc;
        break;
      end
    end
  endtask

  task automatic await_start(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mult_start === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ack0, ack1, err0, err1, mult_start, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ack0/ack1/err0/err1/start/busy=%b required=000000",
               {ack0, ack1, err0, err1, mult_start, busy});
    end
    tests_run++;
    if ({res0, res1, mult_a, mult_b} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_data: res0=%h res1=%h mult_a=%h mult_b=%h required all 0",
               res0, res1, mult_a, mult_b);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    bit got; logic id; int lat; exp_t e; int s0; int k1;
    s0 = start_cnt;
    k1 = ack1_cnt;
    a0 = 8'd3; b0 = 8'd5; req0 = 1'b1;
    sb_q.push_back('{1'b0, 16'h000F, 1'b0, 7});
    await_ack(40, got, id, lat);
    req0 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ack: no ack within budget, required ack0");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res0 !== e.res || err0 !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL single_resp: id=%0d res0=%h err0=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 id, res0, err0, lat, e.id, e.res, e.err, e.lat);
      end
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (start_cnt - s0 !== 1) begin
      tests_failed++;
      $display("FAIL single_starts: start pulses=%0d required 1", start_cnt - s0);
    end
    tests_run++;
    if (ack1_cnt - k1 !== 0 || res0 !== 16'h000F) begin
      tests_failed++;
      $display("FAIL single_hold: ack1 pulses=%0d res0=%h required 0 and 000f", ack1_cnt - k1, res0);
    end
    $display("[TB] single req0 3x5: id=%0d res0=%h err0=%0b lat=%0d", id, res0, err0, lat);
  endtask

  task automatic test_both();
    bit got; logic id; int lat; exp_t e; int prev_cyc;
    logic [15:0] obs_res; logic obs_err;
    do_reset();
    a0 = 8'd255; b0 = 8'd255; a1 = 8'd2; b1 = 8'd7;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back('{k[0], (k[0] ? 16'h000E : 16'hFE01), 1'b0, 7});
    end
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      await_ack(40, got, id, lat);
      if (k == 3 || !got) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tests_run++;
      if (got !== 1'b1) begin
        tests_failed++;
        $display("FAIL both_ack%0d: no ack within budget", k);
        break;
      end
      e = sb_q.pop_front();
      obs_res = id ? res1 : res0;
      obs_err = id ? err1 : err0;
      tests_run++;
      if (id !== e.id || obs_res !== e.res || obs_err !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL both_resp%0d: id=%0d res=%h err=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 k, id, obs_res, obs_err, lat, e.id, e.res, e.err, e.lat);
      end
      if (k > 0) begin
        tests_run++;
        if (cyc - prev_cyc < 5) begin
          tests_failed++;
          $display("FAIL both_spacing%0d: ack gap=%0d required >=5", k, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      $display("[TB] both held ack%0d: id=%0d res=%h lat=%0d", k, id, obs_res, lat);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got; logic id; int lat; exp_t e;
    dp_mode = 1;
    a0 = 8'd9; b0 = 8'd9; req0 = 1'b1;
    sb_q.push_back('{1'b0, 16'h0000, 1'b1, TIMEOUT + 2});
    await_ack(60, got, id, lat);
    req0 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_ack: no ack within budget");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res0 !== e.res || err0 !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL timeout_resp: id=%0d res0=%h err0=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 id, res0, err0, lat, e.id, e.res, e.err, e.lat);
      end
    end
    $display("[TB] timeout req0: res0=%h err0=%0b lat=%0d", res0, err0, lat);
    dp_mode = 0;
    @(negedge clk);
    a0 = 8'd4; b0 = 8'd6; req0 = 1'b1;
    sb_q.push_back('{1'b0, 16'd24, 1'b0, 7});
    await_ack(40, got, id, lat);
    req0 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_recover_ack: no ack within budget");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res0 !== e.res || err0 !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL timeout_recover: id=%0d res0=%h err0=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 id, res0, err0, lat, e.id, e.res, e.err, e.lat);
      end
    end
    $display("[TB] after timeout req0 4x6: res0=%h err0=%0b lat=%0d", res0, err0, lat);
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    bit got; logic id; int lat; exp_t e;
    dp_mode = 2;
    repeat (2) @(negedge clk);
    a1 = 8'd12; b1 = 8'd11; req1 = 1'b1;
    sb_q.push_back('{1'b1, 16'd132, 1'b0, 3});
    await_ack(40, got, id, lat);
    req1 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_ack: no ack within budget");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res1 !== e.res || err1 !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL stale_resp: id=%0d res1=%h err1=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 id, res1, err1, lat, e.id, e.res, e.err, e.lat);
      end
    end
    $display("[TB] stale done req1 12x11: res1=%h lat=%0d", res1, lat);
    dp_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got; logic id; int lat; exp_t e; int k0; int k1;
    a0 = 8'd5; b0 = 8'd5; req0 = 1'b1;
    await_start(20, got);
    req0 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_start: no start within budget");
    end
    repeat (2) @(negedge clk);
    k0 = ack0_cnt;
    k1 = ack1_cnt;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({ack0, ack1, err0, err1, mult_start, busy} !== 6'b0 ||
        {res0, res1, mult_a, mult_b} !== 48'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: ctrl=%b res0=%h res1=%h a=%h b=%h required all 0",
               {ack0, ack1, err0, err1, mult_start, busy}, res0, res1, mult_a, mult_b);
    end
    tests_run++;
    if (dut.r_last_grant !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_last_grant: got=%0b required 1", dut.r_last_grant);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (ack0_cnt !== k0 || ack1_cnt !== k1) begin
      tests_failed++;
      $display("FAIL rstmid_no_ack: ack0 pulses=%0d ack1 pulses=%0d required 0",
               ack0_cnt - k0, ack1_cnt - k1);
    end
    a1 = 8'd6; b1 = 8'd7; req1 = 1'b1;
    sb_q.push_back('{1'b1, 16'd42, 1'b0, 7});
    await_ack(40, got, id, lat);
    req1 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_fresh_ack: no ack within budget");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res1 !== e.res || err1 !== e.err || lat !== e.lat) begin
        tests_failed++;
        $display("FAIL rstmid_fresh: id=%0d res1=%h err1=%0b lat=%0d required id=%0d res=%h err=%0b lat=%0d",
                 id, res1, err1, lat, e.id, e.res, e.err, e.lat);
      end
    end
    $display("[TB] reset mid-wait then req1 6x7: res1=%h lat=%0d", res1, lat);
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    bit got; logic id; int lat; exp_t e;
    a0 = 8'd10; b0 = 8'd20; req0 = 1'b1;
    sb_q.push_back('{1'b0, 16'd200, 1'b0, 7});
    await_start(20, got);
    a0 = 8'd99; b0 = 8'd99; req0 = 1'b0;
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_start: no start within budget");
    end
    await_ack(40, got, id, lat);
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_ack: no ack within budget");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (id !== e.id || res0 !== e.res || err0 !== e.err || mult_a !== 8'd10 || mult_b !== 8'd20) begin
        tests_failed++;
        $display("FAIL hold_resp: id=%0d res0=%h err0=%0b a=%0d b=%0d required id=%0d res=%h err=%0b a=10 b=20",
                 id, res0, err0, mult_a, mult_b, e.id, e.res, e.err);
      end
    end
    $display("[TB] operand hold req0 10x20: res0=%h lat=%0d", res0, lat);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    cyc = 0; last_start_cyc = 0; start_cnt = 0; ack0_cnt = 0; ack1_cnt = 0;
    dp_mode = 0; dp_cnt = 0; dp_done = 1'b0; dp_res = 16'h0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h0; b0 = 8'h0; a1 = 8'h0; b1 = 8'h0;
    reset = 1'b1;

    test_reset();
    test_single();
    test_both();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    test_operand_hold();

    tests_run++;
    if (sb_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mult_arbiter
